uart_rx: RTL and testbench

// - 8N1 UART receiver on the SoC side; drives a byte stream into the core from uart_rx_i.
// - Counterpart of the SoC UART transmitter. Same FREQ/BAUD convention, so the sim bench can loop uart_tx_o back into it.
// - One-entry output register with a valid/ready handshake; frame errors and overruns are flagged as 1-cycle pulses.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-stream side of the UART receiver: holding-register handshake plus error pulses.
interface uart_rx_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  modport master (
    output data_o,
    output valid_o,
    output frame_err_o,
    output overrun_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  frame_err_o,
    input  overrun_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a one-entry
// output register with valid/ready handshake; frame errors and overruns pulse for one cycle.
module uart_rx #(
  parameter int FREQ = 27000000,
  parameter int BAUD = 115200
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       uart_rx_i,
  uart_rx_if.master  rx_bus
);

  localparam int CLKS_PER_BIT = FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx: FREQ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sync_reg;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      idx_reg, idx_next;
  logic [7:0]      sh_reg, sh_next;
  logic [7:0]      data_reg, data_next;
  logic            valid_reg, valid_next;
  logic            ferr_reg, ferr_next;
  logic            ovr_reg, ovr_next;

  logic rx_s;
  logic tick;
  logic handshake;

  assign rx_s      = sync_reg[1];
  assign tick      = (cnt_reg == '0);
  assign handshake = valid_reg & rx_bus.ready_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_reg <= S_IDLE;
      sync_reg  <= 2'b11;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      sh_reg    <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sync_reg  <= {sync_reg[0], uart_rx_i};
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      sh_reg    <= sh_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = tick ? cnt_reg : cnt_reg - 1'b1;
    idx_next   = idx_reg;
    sh_next    = sh_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    ferr_next  = 1'b0;
    ovr_next   = 1'b0;

    // A delivery in the same cycle overrides this clear in the STOP branch below.
    if (handshake) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          cnt_next   = CW'(HALF_BIT - 1);
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_next = S_DATA;
            idx_next   = '0;
            cnt_next   = CW'(CLKS_PER_BIT - 1);
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_next  = {rx_s, sh_reg[7:1]};
          cnt_next = CW'(CLKS_PER_BIT - 1);
          if (idx_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            state_next = S_IDLE;
            if (!valid_reg || handshake) begin
              data_next  = sh_reg;
              valid_next = 1'b1;
            end else begin
              ovr_next = 1'b1;
            end
          end else begin
            ferr_next  = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Stay here while the line is held low so a break gives one error, not many.
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign rx_bus.data_o      = data_reg;
  assign rx_bus.valid_o     = valid_reg;
  assign rx_bus.frame_err_o = ferr_reg;
  assign rx_bus.overrun_o   = ovr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx against a frame-level model of expected bytes and flags.
module tb_uart_rx;
  localparam int FREQ = 460800;
  localparam int BAUD = 115200;
  localparam int CPB  = 4;

  logic clk = 1'b0;
  logic rstn;
  logic line;

  uart_rx_if bus ();

  always #5 clk = ~clk;

  uart_rx #(
    .FREQ (FREQ),
    .BAUD (BAUD)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .uart_rx_i (line),
    .rx_bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model: bytes the consumer should see, in order, plus expected flag counts.
  logic [7:0] exp_q[$];
  int  n_exp_total = 0;
  int  n_rx        = 0;
  int  exp_ferr    = 0;
  int  exp_ovr     = 0;
  int  seen_ferr   = 0;
  int  seen_ovr    = 0;
  bit  model_full  = 1'b0;

  logic       prev_rstn  = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus.frame_err_o === 1'b1) seen_ferr++;
      if (bus.overrun_o === 1'b1) seen_ovr++;
      if (prev_rstn && prev_valid && !prev_ready) begin
        check_eq("hold_valid", {31'b0, bus.valid_o}, 32'd1);
        check_eq("hold_data", {24'b0, bus.data_o}, {24'b0, prev_data});
      end
      if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
        n_rx++;
        $display("[TB] rx byte 0x%02h", bus.data_o);
        if (exp_q.size() > 0) begin
          check_eq("rx_data", {24'b0, bus.data_o}, {24'b0, exp_q.pop_front()});
        end
      end
    end
    prev_rstn  = rstn;
    prev_valid = bus.valid_o;
    prev_ready = bus.ready_i;
    prev_data  = bus.data_o;
  end

  task automatic drive(input logic v, input int n);
    line = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      drive(b[i], CPB);
    end
    drive(stop_ok, CPB);
    if (stop_ok) begin
      if (model_full) begin
        exp_ovr++;
      end else begin
        exp_q.push_back(b);
        n_exp_total++;
        if (!bus.ready_i) model_full = 1'b1;
      end
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic end_check(input string name);
    $display("[TB] checkpoint %s", name);
    check_eq("rx_count", n_rx, n_exp_total);
    check_eq("ferr_count", seen_ferr, exp_ferr);
    check_eq("ovr_count", seen_ovr, exp_ovr);
  endtask

  task automatic check_all_zero(input string name);
    $display("[TB] reset check %s", name);
    check_eq("rst_data", {24'b0, bus.data_o}, 32'd0);
    check_eq("rst_valid", {31'b0, bus.valid_o}, 32'd0);
    check_eq("rst_ferr", {31'b0, bus.frame_err_o}, 32'd0);
    check_eq("rst_ovr", {31'b0, bus.overrun_o}, 32'd0);
  endtask

  initial begin
    rstn        = 1'b0;
    line        = 1'b1;
    bus.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("power_on");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1'b1, 10);

    send_frame(8'hA5, 1'b1);
    drive(1'b1, 12);
    end_check("single_a5");

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    drive(1'b1, 12);
    end_check("back_to_back");

    for (int k = 0; k < 24; k++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 1) == 1) drive(1'b1, $urandom_range(1, 8));
    end
    drive(1'b1, 12);
    end_check("random");

    bus.ready_i = 1'b0;
    send_frame(8'h12, 1'b1);
    drive(1'b1, 8);
    send_frame(8'h34, 1'b1);
    drive(1'b1, 12);
    @(negedge clk);
    check_eq("ovr_data", {24'b0, bus.data_o}, 32'h12);
    check_eq("ovr_valid", {31'b0, bus.valid_o}, 32'd1);
    check_eq("ovr_pulses", seen_ovr, exp_ovr);
    @(posedge clk);
    #1;
    bus.ready_i = 1'b1;
    model_full  = 1'b0;
    drive(1'b1, 4);
    @(negedge clk);
    check_eq("ovr_valid_drop", {31'b0, bus.valid_o}, 32'd0);
    @(posedge clk);
    #1;
    end_check("overrun");

    send_frame(8'h3C, 1'b0);
    drive(1'b0, 36);
    drive(1'b1, 12);
    end_check("frame_error");
    send_frame(8'h7E, 1'b1);
    drive(1'b1, 12);
    end_check("after_break");

    drive(1'b0, 1);
    drive(1'b1, 16);
    end_check("glitch");

    // Park a byte in the holding register, then reset in the middle of the next frame.
    bus.ready_i = 1'b0;
    send_frame(8'h5A, 1'b1);
    drive(1'b1, 8);
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b1, 2);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("mid_frame");
    @(posedge clk);
    #1;
    n_exp_total -= exp_q.size();
    exp_q.delete();
    model_full  = 1'b0;
    bus.ready_i = 1'b1;
    drive(1'b1, 20);
    end_check("post_reset_idle");
    send_frame(8'h81, 1'b1);
    drive(1'b1, 12);
    end_check("post_reset_81");

    check_eq("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
